// File: rtl/if_stage_hazard.sv
// Instruction-fetch stage: owns the PC and IF/ID register, detects load-use
// hazards against the ID/EX load, and flushes on an EX-resolved taken branch.
module if_stage_hazard #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            ex_load,
  input  logic [3:0]      ex_rd,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc4,
  output logic            ifid_valid,
  output logic            ctrl_sel,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
);

  localparam logic [PC_W-1:0] LP_INC      = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);
  localparam logic [15:0]     LP_CNT_MAX  = 16'hFFFF;

  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ifid_instr;
  logic [PC_W-1:0] r_ifid_pc4;
  logic            r_ifid_valid;
  logic [15:0]     r_stall_cnt;
  logic [15:0]     r_flush_cnt;

  logic            w_use_rn;
  logic            w_use_rm;
  logic            w_use_rd;
  logic            w_hazard;
  logic [PC_W-1:0] w_pc_inc;
  logic [3:0]      w_opc;

  assign w_opc    = r_ifid_instr[24:21];
  assign w_pc_inc = r_pc + LP_INC;

  // Source-register usage of the instruction sitting in IF/ID; MOV/MVN have no Rn.
  always_comb begin
    w_use_rn = 1'b0;
    w_use_rm = 1'b0;
    w_use_rd = 1'b0;
    if (r_ifid_instr != 32'd0) begin
      if (r_ifid_instr[27:25] == 3'b000) begin
        w_use_rn = !((w_opc == 4'b1101) || (w_opc == 4'b1111));
        w_use_rm = 1'b1;
      end else if (r_ifid_instr[27:25] == 3'b001) begin
        w_use_rn = !((w_opc == 4'b1101) || (w_opc == 4'b1111));
      end else if (r_ifid_instr[27:26] == 2'b01) begin
        w_use_rn = 1'b1;
        w_use_rd = !r_ifid_instr[20];
      end
    end
  end

  assign w_hazard = ex_load && r_ifid_valid &&
                    ((w_use_rn && (r_ifid_instr[19:16] == ex_rd)) ||
                     (w_use_rm && (r_ifid_instr[3:0]   == ex_rd)) ||
                     (w_use_rd && (r_ifid_instr[15:12] == ex_rd)));

  // Priority: flush over stall over normal fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= LP_RESET_PC;
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
      r_stall_cnt  <= 16'd0;
      r_flush_cnt  <= 16'd0;
    end else if (branch_taken) begin
      r_pc         <= branch_target;
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
      if (r_flush_cnt != LP_CNT_MAX) r_flush_cnt <= r_flush_cnt + 16'd1;
    end else if (w_hazard) begin
      if (r_stall_cnt != LP_CNT_MAX) r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_pc         <= w_pc_inc;
      r_ifid_instr <= imem_data;
      r_ifid_pc4   <= w_pc_inc;
      r_ifid_valid <= 1'b1;
    end
  end

  assign ctrl_sel   = r_ifid_valid && !w_hazard && !branch_taken;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: doc/if_stage_hazard.md
# if_stage_hazard

Instruction-fetch stage with integrated load-use hazard detection and branch flush for the ARM pipeline. Owns the program counter and the IF/ID register. Drives the instruction-ROM address and the control-unit select that injects NOPs into ID/EX. Sits directly upstream of the decode stage and control-signal multiplexer; consumes redirect and load information fed back from EX.

## Interface
Parameters:
- PC_W, 8, program-counter / ROM address width
- PC_INC, 4, PC increment per fetch
- RESET_PC, 0, PC value on reset

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_addr  out  PC_W  ROM address, always equal to pc
- imem_data  in  32  ROM instruction, combinational from imem_addr
- branch_taken  in  1  EX-stage resolved taken branch/BL
- branch_target  in  PC_W  redirect address, valid with branch_taken
- ex_load  in  1  ID/EX holds a load (id_ex_load)
- ex_rd  in  4  destination register of that load
- pc  out  PC_W  current fetch address
- ifid_instr  out  32  instruction presented to decode
- ifid_pc4  out  PC_W  fetch address of ifid_instr plus PC_INC
- ifid_valid  out  1  ifid_instr is a real fetched instruction
- ctrl_sel  out  1  mux select S: 1 passes control-unit outputs, 0 forces all-zero NOP controls
- stall_cnt  out  16  load-use stall cycles, saturating
- flush_cnt  out  16  branch flushes, saturating

## Operation
- Source-register usage of ifid_instr (I):
  - I == 0: NOP, no sources.
  - I[27:25]==000: uses Rn=I[19:16] unless opcode I[24:21] is 1101/1111; always uses Rm=I[3:0].
  - I[27:25]==001: uses Rn unless opcode 1101/1111.
  - I[27:26]==01: uses Rn; if I[20]==0 (store) also uses Rd=I[15:12].
  - Otherwise none.
- hazard = ex_load & ifid_valid & (any used source equals ex_rd).
- Per-cycle action, priority top-down:
  - FLUSH (branch_taken): pc <= branch_target; ifid_instr <= 0; ifid_valid <= 0; ifid_pc4 <= 0; flush_cnt++.
  - STALL (hazard): pc and IF/ID hold; stall_cnt++.
  - RUN: pc <= pc + PC_INC; ifid_instr <= imem_data; ifid_pc4 <= pc + PC_INC; ifid_valid <= 1.
- ctrl_sel = ifid_valid & ~hazard & ~branch_taken (combinational).
- Arithmetic: pc add is modulo 2^PC_W; wrap from max to 0 is silent. Counters stick at 16'hFFFF.
- Simultaneous branch_taken and hazard: FLUSH wins; stall_cnt does not increment.
- Stall duration: exactly one cycle per load-use pair, because the bubble clears ex_load.

## Timing
- Reset (async, immediate):
  - pc = RESET_PC
  - ifid_instr = 0, ifid_pc4 = 0, ifid_valid = 0
  - ctrl_sel = 0, stall_cnt = 0, flush_cnt = 0
- Reset mid-operation discards the in-flight instruction and any pending redirect. First fetch is from RESET_PC on the first rising edge after reset deasserts.
- Fetch latency: the instruction at address A appears on ifid_instr one edge after pc==A.
- Branch penalty: branch_taken sampled at edge N, target instruction on ifid_instr after edge N+1, one NOP between.
- Inputs branch_taken, ex_load and ex_rd are sampled only at the rising edge.

## Test plan
- Reset then run: ROM[0..3] = non-hazard ADDs, reset released at edge 0 -> pc 0,4,8,12 on successive edges; ifid_pc4 trails by one cycle; ctrl_sel=1 from the first valid cycle.
- Load-use stall: ex_load=1, ex_rd=3 while ifid_instr = ADD R1,R3,R2 (register form) -> ctrl_sel=0 for one cycle; pc and ifid_instr hold; stall_cnt=1; next cycle resumes.
- No false stall: ex_load=1, ex_rd=3 with ifid_instr = MOV R1,R3 immediate-form/NOP -> no stall, pc advances.
- Branch flush: branch_taken=1, branch_target=8'h40 at pc=8'h10 -> next pc=8'h40, ifid_valid=0, ctrl_sel=0, flush_cnt=1; ROM[0x40] appears one cycle later.
- Branch plus hazard in the same cycle -> FLUSH only: pc=target, stall_cnt unchanged. PC wrap: at pc=8'hFC, RUN -> pc=8'h00.
- Async reset mid-stall: pulse reset between edges -> all outputs immediately at reset values; counters return to 0.
